// File: rtl/wb_trace_buf.sv
// Retirement-trace capture FIFO fed by the core's write-back debug stream.
// Optional macro WB_TRACE_SEQ_EN adds a 16-bit capture sequence tag (trace_seq).
module wb_trace_buf #(
   parameter int DEPTH   = 16,
   parameter int SKIP_R0 = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic [31:0]                debug_wb_pc,
   input  logic [3:0]                 debug_wb_rf_we,
   input  logic [4:0]                 debug_wb_rf_wnum,
   input  logic [31:0]                debug_wb_rf_wdata,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [31:0]                trace_pc,
   output logic [4:0]                 trace_wnum,
   output logic [31:0]                trace_wdata,
   output logic [$clog2(DEPTH):0]     trace_count,
   output logic                       overflow,
   output logic [15:0]                drop_cnt
`ifdef WB_TRACE_SEQ_EN
   ,
   output logic [15:0]                trace_seq
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef WB_TRACE_SEQ_EN
   localparam int EW = 85;
`else
   localparam int EW = 69;
`endif

   // Output handshake: an entry transfers on a clk edge where trace_valid
   // and trace_ready are both 1; trace_* hold steady while valid && !ready.

   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [CW-1:0]  count;
   logic           cap;
   logic           pop;
   logic           push;
   logic           drop;
   logic [EW-1:0]  wr_entry;
   logic [EW-1:0]  head;

`ifdef WB_TRACE_SEQ_EN
   logic [15:0]    seq_cnt;
`endif

   always_comb begin
      cap  = (|debug_wb_rf_we) && !((SKIP_R0 != 0) && (debug_wb_rf_wnum == 5'd0));
      pop  = (count != '0) && trace_ready;
      // A full FIFO still accepts a capture when the head leaves in the same edge.
      push = cap && ((count < FULL_CNT) || pop);
      drop = cap && !push;
   end

`ifdef WB_TRACE_SEQ_EN
   assign wr_entry = {seq_cnt, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
`else
   assign wr_entry = {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
`endif

   assign head        = mem[rd_ptr];
   assign trace_valid = (count != '0);
   assign trace_pc    = head[68:37];
   assign trace_wnum  = head[36:32];
   assign trace_wdata = head[31:0];
   assign trace_count = count;
`ifdef WB_TRACE_SEQ_EN
   assign trace_seq   = head[84:69];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !clear) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clear) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

`ifdef WB_TRACE_SEQ_EN
   // Advances on every qualifying capture, dropped or not, so gaps mark drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        seq_cnt <= '0;
      else if (clear) seq_cnt <= '0;
      else if (cap)   seq_cnt <= seq_cnt + 1'b1;
   end
`endif

endmodule
